fb_line_fetch: RTL and testbench

Frame-buffer line prefetcher sitting directly upstream of the VGA timing controller. It watches the controller's `line`/`offset` outputs, prefetches the next display row from frame-buffer memory into a ping-pong line buffer over a request/grant read port, and returns the 3-bit `{r,g,b}` for the current `offset` combinationally. The controller registers that value on its next clock edge.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_line_fetch_line_buf.sv | 29 ++
 rtl/fb_line_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_fb_line_fetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants, fetch FSM state type and row-wrap helper for the frame-buffer line prefetcher.
package fb_pkg;

  localparam int FB_COLS         = 640;
  localparam int FB_ROWS         = 480;
  localparam int FB_PIX_BITS     = 3;
  localparam int FB_PIX_PER_WORD = 4;

  typedef enum logic [2:0] {
    INIT0,
    INIT1,
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  // Row shown after the given one; the last visible row wraps to row 0.
  function automatic logic [8:0] fb_next_row(input logic [8:0] row);
    return (row == 9'(FB_ROWS - 1)) ? 9'd0 : row + 9'd1;
  endfunction

endpackage

// File: rtl/fb_line_fetch_line_buf.sv
// Ping-pong line buffer: two banks of one row each, synchronous write, asynchronous read.
module fb_line_buf
  import fb_pkg::*;
#(
  parameter int WORDS = 160,
  parameter int AW    = 8,
  parameter int DW    = FB_PIX_BITS * FB_PIX_PER_WORD
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_wr_bank,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_bank,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_bank0 [WORDS];
  logic [DW-1:0] r_bank1 [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we && !i_wr_bank) r_bank0[i_wr_addr] <= i_wr_data;
    if (i_we &&  i_wr_bank) r_bank1[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = i_rd_bank ? r_bank1[i_rd_addr] : r_bank0[i_rd_addr];

endmodule

// File: rtl/fb_line_fetch.sv
// Frame-buffer line prefetcher feeding the VGA timing controller.
// Optional FB_FETCH_TEST_PATTERN_EN adds i_test_mode, which overrides the pixel with vertical colour bars.
module fb_line_fetch
  import fb_pkg::*;
#(
  parameter logic [16:0] FB_BASE       = 17'd0,
  parameter int          WORDS_PER_ROW = 160,
  parameter int          MAX_OUT       = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [8:0]  i_line,
  input  logic [9:0]  i_offset,
`ifdef FB_FETCH_TEST_PATTERN_EN
  input  logic        i_test_mode,
`endif
  output logic        o_r,
  output logic        o_g,
  output logic        o_b,
  output logic        o_mem_req,
  output logic [16:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [11:0] i_mem_rdata,
  output logic        o_underrun,
  output logic        o_busy
);

  localparam int IDX_W = $clog2(WORDS_PER_ROW + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [IDX_W-1:0] ROW_WORDS = IDX_W'(WORDS_PER_ROW);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_ROW - 1);
  localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(MAX_OUT);

  fetch_state_t     r_state;
  logic [8:0]       r_line_q;
  logic [8:0]       r_target;
  logic [IDX_W-1:0] r_req_idx;
  logic [IDX_W-1:0] r_wr_idx;
  logic [OUT_W-1:0] r_out;
  logic             r_mem_req;
  logic [16:0]      r_mem_addr;
  logic             r_underrun;
  logic             r_busy;

  fetch_state_t     w_nx_state;
  logic [8:0]       w_nx_target;
  logic [IDX_W-1:0] w_nx_req_idx;
  logic [IDX_W-1:0] w_nx_wr_idx;
  logic [OUT_W-1:0] w_nx_out;
  logic             w_nx_underrun;
  logic             w_nx_mem_req;
  logic [16:0]      w_nx_row_base;
  logic             w_start;

  logic w_trig;
  logic w_fire;
  logic w_rv_ok;
  logic w_filling;
  logic w_we;
  logic w_done;

  assign w_trig    = (i_line != r_line_q);
  assign w_fire    = r_mem_req & i_mem_gnt;
  // A response with nothing outstanding is a leftover from before reset and is dropped.
  assign w_rv_ok   = i_mem_rvalid && (r_out != '0);
  assign w_filling = (r_state == INIT0) || (r_state == INIT1) || (r_state == FETCH);
  assign w_we      = w_rv_ok && w_filling;
  assign w_done    = w_we && (r_wr_idx == LAST_WORD);

  always_comb begin
    w_nx_state    = r_state;
    w_nx_target   = r_target;
    w_nx_req_idx  = r_req_idx + IDX_W'(w_fire);
    w_nx_wr_idx   = r_wr_idx + IDX_W'(w_we);
    w_nx_out      = r_out + OUT_W'(w_fire) - OUT_W'(w_rv_ok);
    w_nx_underrun = 1'b0;
    w_start       = 1'b0;
    case (r_state)
      INIT0: begin
        if (w_done) begin
          w_nx_state  = INIT1;
          w_nx_target = 9'd1;
          w_start     = 1'b1;
        end
      end
      INIT1: begin
        if (w_done) w_nx_state = IDLE;
      end
      IDLE: begin
        if (w_trig) begin
          w_nx_state  = FETCH;
          w_nx_target = fb_next_row(i_line);
          w_start     = 1'b1;
        end
      end
      FETCH: begin
        // A row that completes on the same edge as a line change is not abandoned.
        if (w_done && w_trig) begin
          w_nx_target = fb_next_row(i_line);
          w_start     = 1'b1;
        end else if (w_done) begin
          w_nx_state = IDLE;
        end else if (w_trig) begin
          w_nx_state    = DRAIN;
          w_nx_underrun = 1'b1;
        end
      end
      DRAIN: begin
        if (w_nx_out == '0) begin
          w_nx_state  = FETCH;
          w_nx_target = fb_next_row(i_line);
          w_start     = 1'b1;
        end else if (w_trig) begin
          w_nx_underrun = 1'b1;
        end
      end
      default: w_nx_state = INIT0;
    endcase
    if (w_start) begin
      w_nx_req_idx = '0;
      w_nx_wr_idx  = '0;
    end
  end

  assign w_nx_mem_req = ((w_nx_state == INIT0) || (w_nx_state == INIT1) || (w_nx_state == FETCH))
                        && (w_nx_req_idx < ROW_WORDS) && (w_nx_out < OUT_LIMIT);
  assign w_nx_row_base = (17'(w_nx_target) << 7) + (17'(w_nx_target) << 5);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= INIT0;
      r_line_q   <= '0;
      r_target   <= '0;
      r_req_idx  <= '0;
      r_wr_idx   <= '0;
      r_out      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= FB_BASE;
      r_underrun <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_nx_state;
      r_line_q   <= i_line;
      r_target   <= w_nx_target;
      r_req_idx  <= w_nx_req_idx;
      r_wr_idx   <= w_nx_wr_idx;
      r_out      <= w_nx_out;
      r_mem_req  <= w_nx_mem_req;
      r_mem_addr <= FB_BASE + w_nx_row_base + 17'(w_nx_req_idx);
      r_underrun <= w_nx_underrun;
      r_busy     <= (w_nx_state != IDLE);
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_underrun = r_underrun;
  assign o_busy     = r_busy;

  logic             w_in_row;
  logic [IDX_W-1:0] w_rd_addr;
  logic [11:0]      w_rd_data;
  logic [2:0]       w_lane;
  logic [2:0]       w_mem_rgb;
  logic [2:0]       w_rgb;

  assign w_in_row  = (i_offset < 10'(FB_COLS));
  assign w_rd_addr = w_in_row ? IDX_W'(i_offset[9:2]) : '0;

  fb_line_buf #(
    .WORDS (WORDS_PER_ROW),
    .AW    (IDX_W),
    .DW    (12)
  ) u_line_buf (
    .i_clk     (i_clk),
    .i_we      (w_we),
    .i_wr_bank (r_target[0]),
    .i_wr_addr (r_wr_idx),
    .i_wr_data (i_mem_rdata),
    .i_rd_bank (i_line[0]),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    case (i_offset[1:0])
      2'd0:    w_lane = w_rd_data[2:0];
      2'd1:    w_lane = w_rd_data[5:3];
      2'd2:    w_lane = w_rd_data[8:6];
      default: w_lane = w_rd_data[11:9];
    endcase
  end

  assign w_mem_rgb = w_in_row ? w_lane : 3'b000;

`ifdef FB_FETCH_TEST_PATTERN_EN
  assign w_rgb = i_test_mode ? i_offset[9:7] : w_mem_rgb;
`else
  assign w_rgb = w_mem_rgb;
`endif

  assign {o_r, o_g, o_b} = w_rgb;

endmodule

// File: tb/tb_fb_line_fetch.sv
// Self-checking bench for fb_line_fetch: in-order memory responder, row-level line-buffer model,
// pixel vector table, randomized fetches and underrun/outstanding-limit sequences.
module tb_fb_line_fetch;

  localparam logic [16:0] FB_BASE = 17'd0;
  localparam int WPR     = 160;
  localparam int MAX_OUT = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [8:0]  i_line = '0;
  logic [9:0]  i_offset = '0;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [11:0] i_mem_rdata = '0;
  logic        o_r, o_g, o_b, o_mem_req, o_underrun, o_busy;
  logic [16:0] o_mem_addr;
`ifdef FB_FETCH_TEST_PATTERN_EN
  logic        i_test_mode = 1'b0;
`endif

  fb_line_fetch #(.FB_BASE(FB_BASE), .WORDS_PER_ROW(WPR), .MAX_OUT(MAX_OUT)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_line       (i_line),
    .i_offset     (i_offset),
`ifdef FB_FETCH_TEST_PATTERN_EN
    .i_test_mode  (i_test_mode),
`endif
    .o_r          (o_r),
    .o_g          (o_g),
    .o_b          (o_b),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_underrun   (o_underrun),
    .o_busy       (o_busy)
  );

  always #20 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gnt_mode = 1;
  int lat_min = 2;
  int lat_max = 2;
  int last_due = 0;
  int max_pend = 0;
  int under_cnt = 0;
  int cur_line = 0;
  int pend_addr[$];
  int pend_due[$];
  int glog[$];
  int bank_row[2][WPR];

  typedef struct {
    logic [8:0] line;
    logic [9:0] offset;
    logic [2:0] exp;
  } pix_vec_t;

  int tbl_line [16] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 2, 2, 479, 3, 1, 1, 1};
  int tbl_off  [16] = '{5, 0, 3, 639, 640, 1, 2, 300, 1023, 10, 638, 12, 7, 4, 700, 250};

  function automatic logic [11:0] frame_word(input int addr);
    logic [31:0] h;
    h = 32'(addr) * 32'd2654435761;
    return h[27:16];
  endfunction

  function automatic logic [2:0] exp_pix(input int line, input int off);
    int row;
    logic [11:0] w;
    if (off >= 640) return 3'b000;
    row = bank_row[line % 2][off / 4];
    w = frame_word(int'(FB_BASE) + row * WPR + off / 4);
    return 3'((w >> (3 * (off % 4))) & 12'h7);
  endfunction

  function automatic int next_row(input int row);
    return (row == 479) ? 0 : row + 1;
  endfunction

  task automatic complete_fetch(input int row);
    for (int w = 0; w < WPR; w++) bank_row[row % 2][w] = row;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_pix(input string name, input int line, input int off);
    i_line = 9'(line);
    i_offset = 10'(off);
    #1;
    check(name, int'({o_r, o_g, o_b}), int'(exp_pix(line, off)));
  endtask

  task automatic check_log(input string name, input int row, input int nwords);
    int bad;
    bad = -1;
    tests++;
    if (glog.size() != nwords) begin
      fails++;
      $display("[TB] FAIL %s: got %0d requests, expected %0d", name, glog.size(), nwords);
    end else begin
      for (int i = 0; i < nwords; i++)
        if (bad < 0 && glog[i] != int'(FB_BASE) + row * WPR + i) bad = i;
      if (bad >= 0) begin
        fails++;
        $display("[TB] FAIL %s: request %0d address got %0d, expected %0d",
                 name, bad, glog[bad], int'(FB_BASE) + row * WPR + bad);
      end
    end
  endtask

  // One clock of the memory model: grant per policy, return responses in order after a latency.
  task automatic step();
    logic req_now;
    int   addr_now;
    logic g;
    int   lat;
    req_now = o_mem_req;
    addr_now = int'(o_mem_addr);
    case (gnt_mode)
      0:       g = 1'b0;
      1:       g = 1'b1;
      default: g = 1'($urandom_range(0, 1));
    endcase
    i_mem_gnt = g;
    if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata = frame_word(pend_addr[0]);
      pend_due.delete(0);
      pend_addr.delete(0);
    end else begin
      i_mem_rvalid = 1'b0;
      i_mem_rdata = 12'($urandom);
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (!i_reset) begin
      pend_due.delete();
      pend_addr.delete();
    end else if (req_now && g) begin
      lat = $urandom_range(lat_min, lat_max);
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      pend_due.push_back(last_due);
      pend_addr.push_back(addr_now);
      glog.push_back(addr_now);
    end
    if (pend_due.size() > max_pend) max_pend = pend_due.size();
    if (o_underrun) under_cnt++;
  endtask

  task automatic run_until_idle(input string name, input int maxc);
    int n;
    step();
    n = 1;
    while (o_busy && n < maxc) begin
      step();
      n++;
    end
    check(name, int'(o_busy), 0);
  endtask

  task automatic applyStimulus();
    pix_vec_t tbl [16];
    int L;

    #1 i_reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("reset_busy", int'(o_busy), 1);
    check("reset_req", int'(o_mem_req), 0);
    check("reset_addr", int'(o_mem_addr), int'(FB_BASE));
    check("reset_underrun", int'(o_underrun), 0);

    i_reset = 1'b1;
    gnt_mode = 1; lat_min = 2; lat_max = 2;
    glog.delete();
    run_until_idle("init_done", 2000);
    check_log("init_addrs", 0, 2 * WPR);
    complete_fetch(0);
    complete_fetch(1);

    glog.delete();
    i_line = 9'd1;
    step();
    check("trig_req", int'(o_mem_req), 1);
    check("trig_addr", int'(o_mem_addr), int'(FB_BASE) + 2 * WPR);
    run_until_idle("row2_done", 2000);
    check_log("row2_addrs", 2, WPR);
    complete_fetch(2);
    cur_line = 1;

    for (int i = 0; i < 16; i++) begin
      tbl[i].line = 9'(tbl_line[i]);
      tbl[i].offset = 10'(tbl_off[i]);
      tbl[i].exp = exp_pix(tbl_line[i], tbl_off[i]);
    end
    gnt_mode = 0;
    for (int i = 0; i < 16; i++) begin
      i_line = tbl[i].line;
      i_offset = tbl[i].offset;
      #1;
      check($sformatf("pix_tbl%0d", i), int'({o_r, o_g, o_b}), int'(tbl[i].exp));
      step();
    end
    step();
    gnt_mode = 1;
    run_until_idle("tbl_refetch", 2000);
    complete_fetch(next_row(1));
    cur_line = 1;

    gnt_mode = 2; lat_min = 1; lat_max = 4;
    for (int it = 0; it < 6; it++) begin
      do L = $urandom_range(0, 470); while (L == cur_line);
      glog.delete();
      i_line = 9'(L);
      run_until_idle("rnd_done", 3000);
      check_log("rnd_addrs", L + 1, WPR);
      complete_fetch(L + 1);
      for (int k = 0; k < 3; k++) check_pix("rnd_pix", L + 1, $urandom_range(0, 639));
      glog.delete();
      run_until_idle("rnd_done2", 3000);
      check_log("rnd_addrs2", next_row(L + 1), WPR);
      complete_fetch(next_row(L + 1));
      cur_line = L + 1;
    end

    gnt_mode = 1; lat_min = 2; lat_max = 2;
    glog.delete();
    i_line = 9'd479;
    run_until_idle("wrap_done", 2000);
    check_log("wrap_addrs", 0, WPR);
    complete_fetch(0);
    check_pix("wrap_pix_640", 0, 640);
    check_pix("wrap_pix_100", 0, 100);
    run_until_idle("wrap_done2", 2000);
    complete_fetch(1);
    cur_line = 0;

    gnt_mode = 0;
    under_cnt = 0;
    glog.delete();
    i_line = 9'd200;
    for (int i = 0; i < 1000; i++) step();
    check("stall_busy", int'(o_busy), 1);
    check("stall_grants", glog.size(), 0);
    i_line = 9'd300;
    step();
    check("underrun_pulse", int'(o_underrun), 1);
    check("underrun_req", int'(o_mem_req), 0);
    step();
    check("underrun_end", int'(o_underrun), 0);
    check("refetch_req", int'(o_mem_req), 1);
    check("refetch_addr", int'(o_mem_addr), int'(FB_BASE) + 301 * WPR);
    gnt_mode = 1;
    run_until_idle("refetch_done", 2000);
    check_log("refetch_addrs", 301, WPR);
    check("underrun_count", under_cnt, 1);
    complete_fetch(301);
    cur_line = 300;

    lat_min = 20; lat_max = 20;
    glog.delete();
    i_line = 9'd100;
    for (int i = 0; i < 8; i++) step();
    check("maxout_req", int'(o_mem_req), 0);
    check("maxout_grants", glog.size(), MAX_OUT);
    i_line = 9'd101;
    step();
    check("drain_underrun", int'(o_underrun), 1);
    glog.delete();
    run_until_idle("drain_done", 3000);
    check_log("drain_refetch", 102, WPR);
    complete_fetch(102);
    for (int k = 0; k < 4; k++) check_pix("drain_nowrite", 101, 4 * k + 1 + k);
    check("max_outstanding", max_pend, MAX_OUT);

`ifdef FB_FETCH_TEST_PATTERN_EN
    i_test_mode = 1'b1;
    i_offset = 10'd300;
    #1;
    check("test_pattern", int'({o_r, o_g, o_b}), 2);
    i_test_mode = 1'b0;
`endif
  endtask

  task automatic checkOutput();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

endmodule
